// File: rtl/trolley_pkg.sv
// trolley_pkg: shared constants and state encodings for the motor command receiver
package trolley_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int MOTOR_W = 3;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {WAIT_SYNC, GOT_SYNC, GOT_L, GOT_R} parse_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: rxd synchronizer plus 8N1 byte receiver with mid-bit sampling
module uart_rx_byte
    import trolley_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       fr_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_MID = CW'(CLKS_PER_BIT / 2 - 1);
    logic [1:0]    r_sync;
    logic          w_rx;
    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_armed;
    assign w_rx = r_sync[1];
    // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit
    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) r_sync <= 2'b11;
        else r_sync <= {r_sync[0], rxd};
    // Byte FSM; r_armed records that the line was seen high, so a start needs a real 1->0 edge
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_armed    <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            fr_err     <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            fr_err     <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt   <= '0;
                    r_armed <= w_rx;
                    if (r_armed && !w_rx) r_state <= START;
                end
                START: begin
                    r_cnt <= (r_cnt == C_MID) ? '0 : r_cnt + CW'(1);
                    r_bit <= '0;
                    if (r_cnt == C_MID) r_state <= w_rx ? IDLE : DATA;
                end
                DATA: begin
                    r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= STOP;
                    end
                end
                STOP: begin
                    r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_state    <= IDLE;
                        r_armed    <= w_rx;
                        byte_valid <= w_rx;
                        fr_err     <= !w_rx;
                        if (w_rx) byte_data <= r_shift;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/trolley_motor_cmd_rx.sv
// trolley_motor_cmd_rx: validates A5/L/R/CHK frames and drives motor commands with a watchdog
module trolley_motor_cmd_rx
    import trolley_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20,
    parameter int WDOG_CYCLES  = 25_000_000
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               rxd,
    output logic [MOTOR_W-1:0] motor_l,
    output logic [MOTOR_W-1:0] motor_r,
    output logic               frame_valid,
    output logic               frame_err,
    output logic               wdog_stop,
    output logic               byte_valid,
    output logic [7:0]         byte_data
);
    localparam int TLIM = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TLIM + 1);
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic          w_byte_valid;
    logic [7:0]    w_byte_data;
    logic          w_fr_err;
    logic          w_timeout;
    logic [7:0]    w_sum;
    logic          w_ok;
    parse_state_t  r_pstate;
    logic [7:0]    r_l;
    logic [7:0]    r_r;
    logic [TW-1:0] r_tcnt;
    logic [WW-1:0] r_wcnt;
    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .rxd           (rxd),
        .byte_valid    (w_byte_valid),
        .byte_data     (w_byte_data),
        .fr_err        (w_fr_err)
    );
    assign byte_valid = w_byte_valid;
    assign byte_data  = w_byte_data;
    assign w_timeout  = (r_tcnt >= TW'(TLIM)) && !w_byte_valid;
    assign w_sum      = SYNC_BYTE + r_l + r_r;
    assign w_ok       = (w_byte_data == w_sum) && (r_l[7:3] == 5'd0) && (r_r[7:3] == 5'd0);
    // Saturating count of cycles since the last received byte
    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) r_tcnt <= '0;
        else if (w_byte_valid) r_tcnt <= '0;
        else if (r_tcnt != TW'(TLIM)) r_tcnt <= r_tcnt + TW'(1);
    // Frame parser and watchdog; an accepted frame is written last so it beats a same-cycle expiry
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_pstate    <= WAIT_SYNC;
            r_l         <= '0;
            r_r         <= '0;
            r_wcnt      <= '0;
            motor_l     <= '0;
            motor_r     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            wdog_stop   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (r_wcnt != WW'(WDOG_CYCLES)) r_wcnt <= r_wcnt + WW'(1);
            else begin
                motor_l   <= '0;
                motor_r   <= '0;
                wdog_stop <= 1'b1;
            end
            if (r_pstate != WAIT_SYNC && (w_fr_err || w_timeout)) begin
                frame_err <= 1'b1;
                r_pstate  <= WAIT_SYNC;
            end else if (w_byte_valid) begin
                case (r_pstate)
                    WAIT_SYNC: if (w_byte_data == SYNC_BYTE) r_pstate <= GOT_SYNC;
                    GOT_SYNC: begin
                        r_l      <= w_byte_data;
                        r_pstate <= GOT_L;
                    end
                    GOT_L: begin
                        r_r      <= w_byte_data;
                        r_pstate <= GOT_R;
                    end
                    GOT_R: begin
                        r_pstate    <= WAIT_SYNC;
                        frame_valid <= w_ok;
                        frame_err   <= !w_ok;
                        if (w_ok) begin
                            motor_l   <= r_l[MOTOR_W-1:0];
                            motor_r   <= r_r[MOTOR_W-1:0];
                            wdog_stop <= 1'b0;
                            r_wcnt    <= '0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trolley_motor_cmd_rx.sv
// tb_trolley_motor_cmd_rx: directed frames with byte and frame scoreboards
module tb_trolley_motor_cmd_rx;
    localparam int CPB = 8;
    typedef struct packed {
        logic       valid;
        logic [2:0] l;
        logic [2:0] r;
        logic       lat;
    } fexp_t;
    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic [2:0] motor_l, motor_r;
    logic       frame_valid, frame_err, wdog_stop, byte_valid;
    logic [7:0] byte_data;
    logic [7:0] bq[$];
    fexp_t      fq[$];
    int         checks = 0, errors = 0;
    int         cyc = 0, last_bv = 0, bytes_seen = 0;
    logic [2:0] cur_l = 3'd0, cur_r = 3'd0;

    trolley_motor_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20), .WDOG_CYCLES(2000)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .rxd           (rxd),
        .motor_l       (motor_l),
        .motor_r       (motor_r),
        .frame_valid   (frame_valid),
        .frame_err     (frame_err),
        .wdog_stop     (wdog_stop),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc++;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a byte or a frame decision
    always @(negedge clk_clk) begin
        if (byte_valid) begin
            bytes_seen++;
            last_bv = cyc;
            if (bq.size() == 0) chk("byte_unexpected", {24'd0, byte_data}, 32'hFFFF_FFFF);
            else chk("byte_data", {24'd0, byte_data}, {24'd0, bq.pop_front()});
        end
        if (frame_valid || frame_err) begin
            if (fq.size() == 0) chk("frame_unexpected", {30'd0, frame_valid, frame_err}, 32'd0);
            else begin
                fexp_t e;
                e = fq.pop_front();
                chk("frame_kind", {30'd0, frame_valid, frame_err}, e.valid ? 32'd2 : 32'd1);
                chk("frame_motor_l", {29'd0, motor_l}, {29'd0, e.l});
                chk("frame_motor_r", {29'd0, motor_r}, {29'd0, e.r});
                if (e.valid) chk("frame_wdog_clear", {31'd0, wdog_stop}, 32'd0);
                if (e.lat) chk("frame_latency", cyc - last_bv, 32'd1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        if (stop) bq.push_back(b);
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(CPB);
        end
        rxd = stop;
        idle(CPB);
        rxd = 1'b1;
    endtask

    task automatic frame(input logic [7:0] l, input logic [7:0] r, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(l);
        send_byte(r);
        send_byte(c);
        idle(20);
    endtask

    task automatic push_ok(input logic [2:0] l, input logic [2:0] r);
        fq.push_back('{valid: 1'b1, l: l, r: r, lat: 1'b1});
        cur_l = l;
        cur_r = r;
    endtask

    task automatic push_err(input logic lat);
        fq.push_back('{valid: 1'b0, l: cur_l, r: cur_r, lat: lat});
    endtask

    initial begin
        int n;
        idle(3);
        chk("rst_motor_l", {29'd0, motor_l}, 32'd0);
        chk("rst_motor_r", {29'd0, motor_r}, 32'd0);
        chk("rst_flags", {28'd0, frame_valid, frame_err, wdog_stop, byte_valid}, 32'd0);
        chk("rst_byte_data", {24'd0, byte_data}, 32'd0);
        reset_reset_n = 1'b1;
        idle(10);
        push_ok(3'd3, 3'd5);
        frame(8'h03, 8'h05, 8'hAD);
        push_err(1'b1);
        frame(8'h03, 8'h05, 8'hAE);
        push_err(1'b1);
        frame(8'h08, 8'h00, 8'hAD);
        push_err(1'b0);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h55, 1'b0);
        idle(20);
        push_ok(3'd1, 3'd2);
        frame(8'h01, 8'h02, 8'hA8);
        push_err(1'b0);
        send_byte(8'hA5);
        send_byte(8'h03);
        idle(170);
        send_byte(8'h05);
        send_byte(8'hAD);
        idle(20);
        chk("timeout_motors_kept", {26'd0, motor_l, motor_r}, {26'd0, 3'd1, 3'd2});
        push_ok(3'd3, 3'd5);
        frame(8'h03, 8'h05, 8'hAD);
        idle(1700);
        chk("wdog_before_limit", {31'd0, wdog_stop}, 32'd0);
        chk("wdog_before_motor", {26'd0, motor_l, motor_r}, {26'd0, 3'd3, 3'd5});
        idle(400);
        chk("wdog_stop_set", {31'd0, wdog_stop}, 32'd1);
        chk("wdog_motors_zero", {26'd0, motor_l, motor_r}, 32'd0);
        cur_l = 3'd0;
        cur_r = 3'd0;
        push_ok(3'd7, 3'd7);
        frame(8'h07, 8'h07, 8'hB3);
        chk("wdog_recovered", {25'd0, wdog_stop, motor_l, motor_r}, {25'd0, 1'b0, 3'd7, 3'd7});
        n = bytes_seen;
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(50);
        chk("glitch_no_byte", bytes_seen, n);
        rxd = 1'b0;
        idle(3 * CPB);
        #2 reset_reset_n = 1'b0;
        #1;
        chk("async_rst_motors", {26'd0, motor_l, motor_r}, 32'd0);
        chk("async_rst_flags", {28'd0, frame_valid, frame_err, wdog_stop, byte_valid}, 32'd0);
        chk("async_rst_byte", {24'd0, byte_data}, 32'd0);
        idle(2);
        rxd = 1'b1;
        idle(2);
        reset_reset_n = 1'b1;
        idle(10);
        cur_l = 3'd0;
        cur_r = 3'd0;
        push_ok(3'd2, 3'd4);
        frame(8'h02, 8'h04, 8'hAB);
        for (int i = 0; i < 200 && (bq.size() + fq.size()) != 0; i++) @(negedge clk_clk);
        chk("scoreboard_drained", bq.size() + fq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
